// File: rtl/simplerisc_pkg.sv
// Shared SimpleRisc definitions: data-memory geometry, opcode values and the
// data-memory responder FSM encoding.
package simplerisc_pkg;

  localparam int DMEM_DEPTH = 1024;
  localparam int WORD_W     = 32;
  localparam int DADDR_W    = 32;
  localparam int WAIT_CNT_W = 4;

  localparam logic [4:0] opcode_ld = 5'b01110;
  localparam logic [4:0] opcode_st = 5'b01111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  // The counter holds the number of WAIT cycles still to run after the current one.
  function automatic logic [WAIT_CNT_W-1:0] wait_init(input int latency);
    return (latency == 0) ? '0 : WAIT_CNT_W'(latency - 1);
  endfunction

endpackage

// File: rtl/simplerisc_dmem_responder_if.sv
// Request/response handshake between the core's MA stage (master) and the
// data-memory responder (slave).
interface simplerisc_dmem_responder_if
  import simplerisc_pkg::*;
#(
  parameter int ADDR_W = DADDR_W,
  parameter int DATA_W = WORD_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_we;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_we, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_we, rsp_err
  );

endinterface

// File: rtl/simplerisc_sp_ram.sv
// Single-port synchronous RAM with registered read; contents are never reset.
// The read register only updates on an enabled read, so it also acts as a hold.
module simplerisc_sp_ram
  import simplerisc_pkg::*;
#(
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int DATA_W = WORD_W,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/simplerisc_dmem_responder.sv
// SimpleRisc data-memory responder: one outstanding ld/st at a time, with
// LATENCY wait states between request accept and response valid.
//
// state   | meaning
// IDLE    | req_ready=1, waiting for a request
// WAIT    | request accepted, counting down wait states
// RESP    | rsp_valid=1, response frozen until rsp_ready
module simplerisc_dmem_responder
  import simplerisc_pkg::*;
#(
  parameter int DEPTH   = DMEM_DEPTH,
  parameter int ADDR_W  = DADDR_W,
  parameter int DATA_W  = WORD_W,
  parameter int LATENCY = 2
) (
  input logic                          clk1,
  input logic                          rst,
  simplerisc_dmem_responder_if.slave   bus
);

  localparam int                    IDX_W    = $clog2(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] CNT_INIT = wait_init(LATENCY);

  dmem_state_e           state_q;
  logic [WAIT_CNT_W-1:0] cnt_q;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic                  rsp_we_q;
  logic                  rsp_err_q;
  logic                  rsp_load_q;

  logic                  addr_ok;
  logic                  accept;
  logic [DATA_W-1:0]     ram_rdata;

  assign addr_ok = (bus.req_addr < ADDR_W'(DEPTH));
  assign accept  = bus.req_valid && req_ready_q;

  // Stores commit and loads are read at the accept edge; nothing touches the RAM otherwise.
  simplerisc_sp_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk1),
    .en_i    (accept && addr_ok),
    .we_i    (bus.req_we),
    .addr_i  (bus.req_addr[IDX_W-1:0]),
    .wdata_i (bus.req_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_load_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            req_ready_q <= 1'b0;
            rsp_we_q    <= bus.req_we;
            rsp_err_q   <= !addr_ok;
            rsp_load_q  <= !bus.req_we && addr_ok;
            if (LATENCY == 0) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_we    = rsp_we_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_load_q ? ram_rdata : '0;

endmodule
